// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetches 16-bit instruction words from an instruction memory that has a
// combinational read port. After reset it first reads a 32-bit reset vector
// from words 0 and 1, then fetches sequentially from that address. Words whose
// top two bits are 2'b11 are two-word instructions: the second word is an
// immediate that is presented on Data_out together with the first word.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   stall           freezes PC, state and held instruction
//   branch_taken    redirect request; wins over stall
//   branch_target   redirect address, valid with branch_taken
//   int_req         level interrupt request, sampled every edge
//   mem_addr        instruction-memory word address
//   mem_data        instruction-memory read data for mem_addr (same cycle)
//   PC_out          address following the presented instruction
//   instruction_out presented instruction, 16'h0000 is a bubble
//   Data_out        immediate word of a two-word instruction, else 0
//   INT_out         interrupt marker for the presented instruction
// ---------------------------------------------------------------------------
module instruction_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        int_req,
    output logic [31:0] mem_addr,
    input  logic [15:0] mem_data,
    output logic [31:0] PC_out,
    output logic [15:0] instruction_out,
    output logic [15:0] Data_out,
    output logic        INT_out
);

    typedef enum logic [1:0] {
        RV_HI,
        RV_LO,
        FETCH,
        FETCH_IMM
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] vec_hi_q, vec_hi_d;
    logic        int_pending_q, int_pending_d;

    logic [31:0] pc_plus_one;
    logic        two_word;
    logic        deliver;

    // PC increments wrap naturally at 32 bits.
    assign pc_plus_one = pc_q + 32'd1;
    assign two_word    = (mem_data[15:14] == 2'b11);

    // Next-state and output logic. Outputs depend on the current memory word
    // so an instruction is presented in the same cycle it is read.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        hold_instr_d    = hold_instr_q;
        vec_hi_d        = vec_hi_q;
        deliver         = 1'b0;
        mem_addr        = pc_q;
        PC_out          = 32'd0;
        instruction_out = 16'h0000;
        Data_out        = 16'h0000;
        INT_out         = 1'b0;

        case (state_q)
            RV_HI: begin
                mem_addr = 32'd0;
                vec_hi_d = mem_data;
                state_d  = RV_LO;
            end

            RV_LO: begin
                mem_addr = 32'd1;
                pc_d     = {vec_hi_q, mem_data};
                state_d  = FETCH;
            end

            FETCH: begin
                if (branch_taken) begin
                    // Redirect: bubble this cycle, restart at the target.
                    pc_d    = branch_target;
                    state_d = FETCH;
                end else if (two_word) begin
                    // First half of a pair: bubble until the immediate arrives.
                    PC_out = pc_plus_one;
                    if (!stall) begin
                        hold_instr_d = mem_data;
                        pc_d         = pc_plus_one;
                        state_d      = FETCH_IMM;
                    end
                end else begin
                    PC_out          = pc_plus_one;
                    instruction_out = mem_data;
                    INT_out         = int_pending_q;
                    if (!stall) begin
                        pc_d    = pc_plus_one;
                        deliver = int_pending_q;
                    end
                end
            end

            FETCH_IMM: begin
                if (branch_taken) begin
                    // The held first word is dropped by returning to FETCH.
                    pc_d    = branch_target;
                    state_d = FETCH;
                end else begin
                    PC_out          = pc_plus_one;
                    instruction_out = hold_instr_q;
                    Data_out        = mem_data;
                    INT_out         = int_pending_q;
                    if (!stall) begin
                        pc_d    = pc_plus_one;
                        state_d = FETCH;
                        deliver = int_pending_q;
                    end
                end
            end

            default: begin
                state_d = RV_HI;
            end
        endcase

        // Sticky interrupt: a new request in the delivery cycle keeps it set.
        int_pending_d = int_req | (int_pending_q & ~deliver);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RV_HI;
            pc_q          <= 32'd0;
            hold_instr_q  <= 16'h0000;
            vec_hi_q      <= 16'h0000;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_instr_q  <= hold_instr_d;
            vec_hi_q      <= vec_hi_d;
            int_pending_q <= int_pending_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Drives instruction_fetch_unit with directed scenarios followed by random
// stall/branch/interrupt traffic. A small instruction memory lives here and
// a behavioural model predicts every output cycle by cycle.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        int_req;
    logic [31:0] mem_addr;
    logic [15:0] mem_data;
    logic [31:0] PC_out;
    logic [15:0] instruction_out;
    logic [15:0] Data_out;
    logic        INT_out;

    int checkCount = 0;
    int passCount  = 0;

    logic [15:0] memTbl [0:255];

    // Model state: phase 0 = reading vector high, 1 = vector low,
    // 2 = fetching, 3 = waiting for the immediate of a pair.
    int          mPhase;
    logic [31:0] mPc;
    logic [15:0] mHold;
    logic [15:0] mVecHi;
    logic        mInt;

    logic [31:0] eAddr;
    logic [31:0] ePcOut;
    logic [15:0] eInstr;
    logic [15:0] eData;
    logic        eInt;
    logic        eSkipPc;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .int_req         (int_req),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .Data_out        (Data_out),
        .INT_out         (INT_out)
    );

    always #5 clk = ~clk;

    // Low 256 words come from the table; everything else is a fixed hash,
    // with the top word forced single-word for the wrap scenario.
    function automatic logic [15:0] memRead(input logic [31:0] a);
        logic [15:0] h;
        if (a < 32'd256) return memTbl[a[7:0]];
        if (a == 32'hFFFF_FFFF) return 16'h0F0F;
        h = a[15:0] * 16'h9E37;
        return h ^ a[31:16];
    endfunction

    always_comb mem_data = memRead(mem_addr);

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic modelReset();
        mPhase = 0;
        mPc    = 32'd0;
        mHold  = 16'h0000;
        mVecHi = 16'h0000;
        mInt   = 1'b0;
    endtask

    // Expected outputs for the current model state and inputs.
    task automatic modelOutputs();
        logic [15:0] w;
        eAddr   = (mPhase == 0) ? 32'd0 : (mPhase == 1) ? 32'd1 : mPc;
        w       = memRead(eAddr);
        ePcOut  = 32'd0;
        eInstr  = 16'h0000;
        eData   = 16'h0000;
        eInt    = 1'b0;
        eSkipPc = 1'b0;
        if (mPhase >= 2) begin
            if (branch_taken) begin
                eSkipPc = 1'b1;
            end else if (mPhase == 3) begin
                ePcOut = mPc + 32'd1;
                eInstr = mHold;
                eData  = w;
                eInt   = mInt;
            end else if (w[15:14] == 2'b11) begin
                ePcOut = mPc + 32'd1;
            end else begin
                ePcOut = mPc + 32'd1;
                eInstr = w;
                eInt   = mInt;
            end
        end
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic modelAdvance();
        logic [15:0] w;
        logic        delivered;
        delivered = 1'b0;
        w = memRead((mPhase == 0) ? 32'd0 : (mPhase == 1) ? 32'd1 : mPc);
        if (mPhase == 0) begin
            mVecHi = w;
            mPhase = 1;
        end else if (mPhase == 1) begin
            mPc    = {mVecHi, w};
            mPhase = 2;
        end else if (branch_taken) begin
            mPc    = branch_target;
            mPhase = 2;
        end else if (!stall) begin
            if (mPhase == 3) begin
                delivered = mInt;
                mPhase    = 2;
            end else if (w[15:14] == 2'b11) begin
                mHold  = w;
                mPhase = 3;
            end else begin
                delivered = mInt;
            end
            mPc = mPc + 32'd1;
        end
        mInt = int_req | (mInt & ~delivered);
    endtask

    task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t, input logic i);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        int_req       = i;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        modelOutputs();
        checkVal({tag, ".mem_addr"}, mem_addr, eAddr);
        if (!eSkipPc) checkVal({tag, ".PC_out"}, PC_out, ePcOut);
        checkVal({tag, ".instr"}, {16'h0, instruction_out}, {16'h0, eInstr});
        checkVal({tag, ".data"}, {16'h0, Data_out}, {16'h0, eData});
        checkVal({tag, ".int"}, {31'h0, INT_out}, {31'h0, eInt});
    endtask

    task automatic advance();
        modelAdvance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input string tag, input logic s, input logic b, input logic [31:0] t, input logic i);
        applyStimulus(s, b, t, i);
        checkOutput(tag);
        advance();
    endtask

    initial begin
        // Memory image: random background, then the directed scenarios.
        for (int k = 0; k < 256; k++) memTbl[k] = 16'($urandom);
        for (int k = 16; k < 160; k++) memTbl[k] = {2'b01, 14'(k)};
        memTbl[8'h00] = 16'h0000;
        memTbl[8'h01] = 16'h0010;
        memTbl[8'h10] = 16'h1234;
        memTbl[8'h11] = 16'hC005;
        memTbl[8'h12] = 16'hABCD;
        memTbl[8'h20] = 16'h2222;
        memTbl[8'h40] = 16'h4444;
        memTbl[8'h50] = 16'hC005;
        memTbl[8'h51] = 16'hABCD;
        memTbl[8'h60] = 16'hC0AA;
        memTbl[8'h61] = 16'hBEEF;
        memTbl[8'h80] = 16'h0880;
        memTbl[8'h90] = 16'hC111;
        memTbl[8'h91] = 16'h2222;

        // Reset state.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        modelReset();
        checkOutput("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();

        // Reset vector: two vector cycles, then word 0x10.
        step("rv_hi", 1'b0, 1'b0, 32'd0, 1'b0);
        step("rv_lo", 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("first");
        checkVal("vec.instr", {16'h0, instruction_out}, 32'h1234);
        checkVal("vec.pc", PC_out, 32'h11);
        checkVal("vec.data", {16'h0, Data_out}, 32'h0);
        advance();

        // Two-word pair following sequentially.
        step("pair1_bubble", 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("pair1_imm");
        checkVal("pair1.pc", PC_out, 32'h13);
        advance();

        // Two-word pair at 0x50.
        step("br50", 1'b0, 1'b1, 32'h50, 1'b0);
        step("pair2_bubble", 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("pair2_imm");
        checkVal("pair2.instr", {16'h0, instruction_out}, 32'hC005);
        checkVal("pair2.data", {16'h0, Data_out}, 32'hABCD);
        checkVal("pair2.pc", PC_out, 32'h52);
        advance();

        // Stall held at 0x20, then branch with stall to 0x40.
        step("br20", 1'b0, 1'b1, 32'h20, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
            checkOutput("stall");
            checkVal("stall.addr", mem_addr, 32'h20);
            checkVal("stall.instr", {16'h0, instruction_out}, 32'h2222);
            advance();
        end
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0);
        checkOutput("stall_branch");
        checkVal("stall_branch.instr", {16'h0, instruction_out}, 32'h0);
        advance();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("after_branch");
        checkVal("after_branch.addr", mem_addr, 32'h40);
        advance();

        // Branch while waiting for an immediate.
        step("br60", 1'b0, 1'b1, 32'h60, 1'b0);
        step("pair3_bubble", 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h80, 1'b0);
        checkOutput("imm_branch");
        checkVal("imm_branch.data", {16'h0, Data_out}, 32'h0);
        advance();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("at80");
        checkVal("at80.addr", mem_addr, 32'h80);
        advance();

        // Interrupt pulsed during a stall.
        step("int_stall", 1'b1, 1'b0, 32'd0, 1'b1);
        step("int_stall2", 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("int_accept");
        checkVal("int_accept.int", {31'h0, INT_out}, 32'h1);
        advance();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("int_after");
        checkVal("int_after.int", {31'h0, INT_out}, 32'h0);
        advance();

        // Interrupt pulsed during the first half of a pair.
        step("br90", 1'b0, 1'b1, 32'h90, 1'b0);
        step("int_pair_first", 1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("int_pair");
        checkVal("int_pair.int", {31'h0, INT_out}, 32'h1);
        advance();
        step("int_pair_after", 1'b0, 1'b0, 32'd0, 1'b0);

        // PC wrap at the top of the address space.
        step("brtop", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("wrap");
        checkVal("wrap.pc", PC_out, 32'h0);
        advance();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("wrapped");
        checkVal("wrapped.addr", mem_addr, 32'h0);
        advance();

        // Reset in the middle of a pair.
        step("br60b", 1'b0, 1'b1, 32'h60, 1'b0);
        step("pair4_bubble", 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("pair4_imm");
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("mid_reset");
        checkVal("mid_reset.instr", {16'h0, instruction_out}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step("rv_hi2", 1'b0, 1'b0, 32'd0, 1'b0);
        step("rv_lo2", 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("restart");
        checkVal("restart.instr", {16'h0, instruction_out}, 32'h1234);
        advance();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic        s, b, i;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            i = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step("rand", s, b, t, i);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk and reset, as the rest of the codebase names them.
REQ-002 clk  input  1  rising-edge clock for all state in the block.
REQ-003 reset  input  1  asynchronous, active-high; forces reset state immediately, independent of clk.
REQ-004 stall  input  1  hazard hold; when 1, the block freezes all state.
REQ-005 branch_taken  input  1  redirect request from a later stage.
REQ-006 branch_target  input  32  redirect address, valid while branch_taken=1.
REQ-007 int_req  input  1  external interrupt request, level, sampled each clk edge.
REQ-008 mem_addr  output  32  instruction-memory word address (combinational read).
REQ-009 mem_data  input  16  instruction-memory read data for mem_addr, same cycle.
REQ-010 PC_out  output  32  address following the presented instruction; drives IF/ID buffer PC input.
REQ-011 instruction_out  output  16  presented instruction; 16'h0000 = NOP bubble.
REQ-012 Data_out  output  16  immediate word for two-word instructions, else 16'h0000.
REQ-013 INT_out  output  1  interrupt marker attached to the presented instruction.

Function
REQ-014 The block SHALL implement states RV_HI, RV_LO, FETCH, FETCH_IMM; its internal registers are PC[31:0], hold_instr[15:0], vec_hi[15:0] and int_pending.
REQ-015 In RV_HI the block SHALL set mem_addr=0, capture mem_data into vec_hi at the clk edge, and go to RV_LO.
REQ-016 In RV_LO the block SHALL set mem_addr=1, load PC={vec_hi,mem_data} at the clk edge, and go to FETCH.
REQ-017 In RV_HI and RV_LO the block SHALL ignore stall and branch_taken, and SHALL drive outputs as a bubble (all zero).
REQ-018 In FETCH and FETCH_IMM the block SHALL set mem_addr=PC.
REQ-019 An instruction SHALL be two-word when mem_data[15:14]=2'b11, and single-word otherwise.
REQ-020 FETCH, single-word: outputs SHALL be instruction_out=mem_data, Data_out=0, PC_out=PC+1, INT_out=int_pending; at the edge PC<=PC+1 and the state stays FETCH.
REQ-021 FETCH, two-word: outputs SHALL be a bubble with PC_out=PC+1; at the edge hold_instr<=mem_data, PC<=PC+1, and the state goes to FETCH_IMM.
REQ-022 FETCH_IMM: outputs SHALL be instruction_out=hold_instr, Data_out=mem_data, PC_out=PC+1, INT_out=int_pending; at the edge PC<=PC+1 and the state goes to FETCH.
REQ-023 PC arithmetic SHALL be modulo 2^32, so 32'hFFFFFFFF+1 wraps to 0 with no flag.
REQ-024 Latency SHALL be 0 cycles from mem_data to outputs; single-word throughput is 1 instruction/cycle and two-word throughput is 1 instruction/2 cycles.
REQ-025 stall=1 (FETCH/FETCH_IMM, branch_taken=0): PC, state, hold_instr and int_pending SHALL hold, and outputs SHALL remain a function of the held state and mem_data.
REQ-026 branch_taken=1 (FETCH/FETCH_IMM): the block SHALL output a bubble that cycle; at the edge PC<=branch_target and the state goes to FETCH, discarding any hold_instr.
REQ-027 branch_taken SHALL take priority over stall when both are 1.
REQ-028 int_req=1 at an edge SHALL set int_pending, which is sticky.
REQ-029 int_pending SHALL clear at the edge on which an instruction with INT_out=1 is accepted (stall=0, branch_taken=0).
REQ-030 A bubble SHALL never carry INT_out=1.
REQ-031 A simultaneous int_req=1 and delivery SHALL leave int_pending=1.
REQ-032 Bubbles SHALL always present Data_out=0 and INT_out=0.

Reset
REQ-033 While reset=1: state=RV_HI, PC=0, hold_instr=0, vec_hi=0, int_pending=0, and outputs are a bubble (PC_out=0, instruction_out=0, Data_out=0, INT_out=0).
REQ-034 Reset asserted mid-operation, including in FETCH_IMM, SHALL abort immediately with no partial instruction presented after release.
REQ-035 After reset deasserts, the first valid instruction SHALL appear 2 cycles later, in FETCH.

Verification
REQ-036 Reset vector: mem[0]=16'h0000, mem[1]=16'h0010, mem[0x10]=16'h1234 -> third cycle after reset release presents instruction_out=16'h1234, PC_out=32'h11, Data_out=0.
REQ-037 Two-word: mem[0x10]=16'hC005, mem[0x11]=16'hABCD -> first cycle a bubble; next cycle instruction_out=16'hC005, Data_out=16'hABCD, PC_out=32'h12.
REQ-038 Stall plus branch: stall held 3 cycles at PC=0x20 -> outputs constant and PC=0x20; then branch_taken=1 with stall=1, target 0x40 -> bubble that cycle, then fetch from 0x40.
REQ-039 Branch in FETCH_IMM: branch_taken=1, target 0x80 -> hold_instr is discarded, the immediate is never presented, and the next fetch is mem_addr=0x80.
REQ-040 Interrupt: int_req pulsed 1 cycle during a stall -> INT_out=1 on the first accepted instruction only, then 0; int_req pulsed during a two-word first half -> INT_out=1 on the completed pair.
REQ-041 Wrap and reset: PC=32'hFFFFFFFF single-word fetch -> PC_out=0, next mem_addr=0; reset asserted mid-FETCH_IMM -> outputs zero immediately and the sequence restarts in RV_HI.
